local_memory_banked: RTL and testbench
======================================

Name: local_memory_banked

Overview:
- Parametrised successor to the two-bank local memory.
- Simple dual-port RAM: one write port, one read port. The W_WIDTH-bit word is split into N_BANK equal slices.
- Per-bank write enables, a registered 2-cycle read pipeline with a valid flag, and write-first collision forwarding.
- Clears its whole array to zero after reset. Sits between datapath engines and local scratch storage.

Parameters:
- W_WIDTH, 32, data word width in bits; must be a multiple of N_BANK.
- W_ADDR, 8, address width in bits; depth = 2**W_ADDR words.
- N_BANK, 4, number of write-enable slices; W_BANK = W_WIDTH/N_BANK; bank 0 = LSBs.

Ports:
- MCLK  in  1  clock, all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- wr_en  in  1  write request, sampled every cycle.
- wr_addr  in  W_ADDR  write address.
- wr_data  in  W_WIDTH  write data.
- wr_be  in  N_BANK  per-bank write enable; bank b written only if wr_en & wr_be[b].
- rd_en  in  1  read request.
- rd_addr  in  W_ADDR  read address.
- rd_data  out  W_WIDTH  registered read data; holds its value between reads.
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- busy  out  1  high while clear sequence runs; requests ignored.
- par_err  out  1  parity error flag; constant 0 unless LOCAL_MEM_PARITY_EN.

Behaviour:
- Reset values, while RST=1 and on the first cycle after release:
  - rd_data=0, rd_valid=0, par_err=0, busy=1.
  - Clear counter = 0. Read pipeline flushed; in-flight reads are dropped and never produce rd_valid.
- FSM has two states:
  - CLEAR, entered on RST. Writes 0 to address = counter, all banks, one address per cycle. Counter increments modulo 2**W_ADDR.
  - CLEAR -> RUN after address 2**W_ADDR-1 is written, so CLEAR lasts exactly 2**W_ADDR cycles after RST deasserts. busy=0 from the first RUN cycle.
  - RST during CLEAR restarts at address 0.
  - In CLEAR, wr_en and rd_en are ignored; no rd_valid is issued.
- RUN write: on the edge ending cycle t, bank b of mem[wr_addr] <= wr_data[b*W_BANK +: W_BANK] if wr_en & wr_be[b]. wr_be=0 with wr_en=1 is a no-op.
- RUN read latency is 2:
  - rd_en at cycle t: stage 1 captures the array word at the edge ending t.
  - rd_data and rd_valid update at the edge ending t+1; rd_valid=1 during t+2 only.
  - Back-to-back reads give one result per cycle.
- Collision: if wr_en=1 and rd_en=1 in the same cycle with wr_addr==rd_addr, the read returns the new data for banks with wr_be[b]=1 and the old data for the other banks (write-first per bank).
  - A write in cycle t+1 to the same address does not affect the read issued at t.
- rd_data is not cleared when rd_valid=0; it keeps the last result.
- Address wrap: none needed; all W_ADDR values are legal. No out-of-range case exists.

Optional Feature:
- Macro LOCAL_MEM_PARITY_EN.
- Defined:
  - Each bank stores one extra even-parity bit, computed on write; CLEAR writes parity 0.
  - On read, parity is recomputed per bank in stage 2.
  - par_err pulses 1 with rd_valid if any bank mismatches; rd_data is still delivered unchanged.
  - Collision-forwarded banks use the forwarded parity.
- Not defined: no parity storage; par_err tied to 0.

Test Plan:
- Defaults; release RST at cycle 0 -> busy=1 for exactly 256 cycles. Then rd_en at addr 0x05 and at 0xFF -> rd_valid 2 cycles later each, rd_data=0x00000000.
- After clear: write 0x12345678 to addr 0x03 (wr_be=4'b1111); read 0x03 next cycle -> rd_valid on read cycle+2 with rd_data=0x12345678. Back-to-back reads of 0x03, 0x04 -> 0x12345678 then 0x00000000 on consecutive cycles.
- Partial write 0xFFFFFFFF, wr_be=4'b0010 to addr 0x03 -> subsequent read returns 0x1234FF78.
- Same-cycle write 0xAABBCCDD, wr_be=4'b0101, plus read, both to addr 0x03 holding 0x12345678 -> rd_data=0x12BB56DD.
- Assert RST for 1 cycle when counter=100 during CLEAR, with a write of 0xDEADBEEF to 0x80 issued during CLEAR -> busy stays high a full 256 cycles after release; read 0x80 returns 0.
- Read issued 1 cycle before RST -> no rd_valid, rd_data=0.
- LOCAL_MEM_PARITY_EN defined: force a flip of stored bit 9 at addr 0x03, then read -> par_err=1 coincident with rd_valid. Without the macro, par_err stays 0 throughout.

Source files
------------

// File: rtl/local_memory_banked.sv
// Simple dual-port scratch RAM with per-bank write enables, 2-cycle read and post-reset clear.
// Optional per-bank even parity is enabled with the LOCAL_MEM_PARITY_EN macro.
module local_memory_banked #(
  parameter int W_WIDTH = 32,
  parameter int W_ADDR  = 8,
  parameter int N_BANK  = 4
) (
  input  logic                MCLK,
  input  logic                RST,
  input  logic                wr_en,
  input  logic [W_ADDR-1:0]   wr_addr,
  input  logic [W_WIDTH-1:0]  wr_data,
  input  logic [N_BANK-1:0]   wr_be,
  input  logic                rd_en,
  input  logic [W_ADDR-1:0]   rd_addr,
  output logic [W_WIDTH-1:0]  rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                par_err
);

  localparam int W_BANK = W_WIDTH / N_BANK;
  localparam int DEPTH  = 2 ** W_ADDR;
`ifdef LOCAL_MEM_PARITY_EN
  localparam int W_PAR  = 1;
`else
  localparam int W_PAR  = 0;
`endif
  localparam int W_STORE = W_BANK + W_PAR;

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t               r_state;
  logic [W_ADDR-1:0]    r_clr_cnt;
  logic                 r_busy;
  logic                 r_s1_valid;
  logic                 r_rd_valid;
  logic [W_WIDTH-1:0]   r_rd_data;

  logic                 w_clear_wr;
  logic                 w_run;
  logic                 w_wr_run;
  logic                 w_rd_acc;
  logic [W_ADDR-1:0]    w_mem_addr;
  logic [W_WIDTH-1:0]   w_merged;
`ifdef LOCAL_MEM_PARITY_EN
  logic [N_BANK-1:0]    w_perr;
  logic                 r_par_err;
`endif

  // Requests are only honoured in RUN and never on a reset cycle.
  assign w_clear_wr = (r_state == S_CLEAR) && !RST;
  assign w_run      = (r_state == S_RUN) && !RST;
  assign w_wr_run   = w_run && wr_en;
  assign w_rd_acc   = w_run && rd_en;
  assign w_mem_addr = w_clear_wr ? r_clr_cnt : wr_addr;

  generate
    for (genvar gi = 0; gi < N_BANK; gi++) begin : g_bank
      logic [W_STORE-1:0] r_mem [DEPTH];
      logic [W_STORE-1:0] r_raw;
      logic               r_hit;
      logic [W_BANK-1:0]  r_fwd;
      logic [W_BANK-1:0]  w_wdata;
      logic [W_STORE-1:0] w_wword;
      logic               w_we;

      assign w_wdata = w_clear_wr ? '0 : wr_data[gi*W_BANK +: W_BANK];
      assign w_we    = w_clear_wr || (w_wr_run && wr_be[gi]);
`ifdef LOCAL_MEM_PARITY_EN
      assign w_wword = {^w_wdata, w_wdata};
`else
      assign w_wword = w_wdata;
`endif

      // Read-before-write array; colliding banks are patched from r_fwd in stage 2.
      always_ff @(posedge MCLK) begin
        if (w_we) begin
          r_mem[w_mem_addr] <= w_wword;
        end
        if (w_rd_acc) begin
          r_raw <= r_mem[rd_addr];
          r_hit <= w_wr_run && wr_be[gi] && (wr_addr == rd_addr);
          r_fwd <= wr_data[gi*W_BANK +: W_BANK];
        end
      end

      assign w_merged[gi*W_BANK +: W_BANK] = r_hit ? r_fwd : r_raw[W_BANK-1:0];
`ifdef LOCAL_MEM_PARITY_EN
      // Forwarded data carries freshly computed parity, so it can never mismatch.
      assign w_perr[gi] = !r_hit && ((^r_raw[W_BANK-1:0]) != r_raw[W_BANK]);
`endif
    end
  endgenerate

  always_ff @(posedge MCLK) begin
    if (RST) begin
      r_state    <= S_CLEAR;
      r_clr_cnt  <= '0;
      r_busy     <= 1'b1;
      r_s1_valid <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
`ifdef LOCAL_MEM_PARITY_EN
      r_par_err  <= 1'b0;
`endif
    end else begin
      r_s1_valid <= w_rd_acc;
      r_rd_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rd_data <= w_merged;
      end
`ifdef LOCAL_MEM_PARITY_EN
      r_par_err  <= r_s1_valid && (|w_perr);
`endif
      case (r_state)
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == '1) begin
            r_state <= S_RUN;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign busy     = r_busy;
`ifdef LOCAL_MEM_PARITY_EN
  assign par_err  = r_par_err;
`else
  assign par_err  = 1'b0;
`endif

endmodule

// File: tb/tb_local_memory_banked.sv
// Self-checking bench for local_memory_banked: directed vector table, hand sequences,
// and randomized traffic against a behavioural memory model.
module tb_local_memory_banked;

  logic        MCLK = 1'b0;
  logic        RST;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        par_err;

  always #5 MCLK = ~MCLK;

  local_memory_banked u_dut (
    .MCLK(MCLK), .RST(RST),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .par_err(par_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: the array, clear progress and the one read awaiting delivery.
  logic [31:0] m_mem [256];
  bit          m_bad [256];
  int          m_left;
  bit          m_run;
  bit          pend_v;
  logic [31:0] pend_d;
  bit          pend_par;
  bit          e_valid;
  logic [31:0] e_data;
  bit          e_par;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit we, input logic [7:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input bit re, input logic [7:0] ra);
    logic [31:0] d;
    RST = rst; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be; rd_en = re; rd_addr = ra;
    @(posedge MCLK);
    #1;
    if (rst) begin
      m_run = 0; m_left = 256; pend_v = 0; pend_par = 0;
      e_valid = 0; e_data = 0; e_par = 0;
    end else begin
      e_valid = pend_v;
      if (pend_v) e_data = pend_d;
      e_par = pend_v && pend_par;
      if (!m_run) begin
        pend_v = 0;
        m_left--;
        if (m_left == 0) begin
          for (int a = 0; a < 256; a++) begin m_mem[a] = 0; m_bad[a] = 0; end
          m_run = 1;
        end
      end else begin
        if (re) begin
          d = m_mem[ra];
          if (we && wa == ra)
            for (int b = 0; b < 4; b++) if (be[b]) d[b*8 +: 8] = wd[b*8 +: 8];
          pend_v = 1; pend_d = d; pend_par = m_bad[ra] && !(we && wa == ra && be[1]);
        end else begin
          pend_v = 0;
        end
        if (we) begin
          for (int b = 0; b < 4; b++) if (be[b]) m_mem[wa][b*8 +: 8] = wd[b*8 +: 8];
          if (be[1]) m_bad[wa] = 0;
        end
      end
    end
    check("rd_valid", {31'd0, rd_valid}, {31'd0, e_valid});
    check("rd_data", rd_data, e_data);
    check("busy", {31'd0, busy}, {31'd0, !m_run});
`ifdef LOCAL_MEM_PARITY_EN
    check("par_err", {31'd0, par_err}, {31'd0, e_par});
`else
    check("par_err", {31'd0, par_err}, 32'd0);
`endif
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 32'h0, 4'h0, 0, 8'h00);
  endtask

  // Counts samples with busy high, starting at the sample right after a reset edge.
  task automatic measure_busy(output int len);
    len = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!busy) break;
      len++;
      idle();
    end
  endtask

  typedef struct {
    bit          we;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          re;
    logic [7:0]  ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];
  int   blen;

  initial begin
    vecs[0] = '{0, 8'h00, 32'h0,        4'h0, 1, 8'h05, 32'h00000000};
    vecs[1] = '{0, 8'h00, 32'h0,        4'h0, 1, 8'hFF, 32'h00000000};
    vecs[2] = '{1, 8'h03, 32'h12345678, 4'hF, 0, 8'h00, 32'h0};
    vecs[3] = '{0, 8'h00, 32'h0,        4'h0, 1, 8'h03, 32'h12345678};
    vecs[4] = '{1, 8'h03, 32'hFFFFFFFF, 4'h2, 0, 8'h00, 32'h0};
    vecs[5] = '{0, 8'h00, 32'h0,        4'h0, 1, 8'h03, 32'h1234FF78};
    vecs[6] = '{1, 8'h03, 32'h12345678, 4'hF, 0, 8'h00, 32'h0};
    vecs[7] = '{1, 8'h03, 32'hAABBCCDD, 4'h5, 1, 8'h03, 32'h12BB56DD};

    step(1, 0, 8'h00, 32'h0, 4'h0, 0, 8'h00);
    step(1, 0, 8'h00, 32'h0, 4'h0, 0, 8'h00);
    measure_busy(blen);
    check("busy_len_initial", blen, 256);

    for (int i = 0; i < 8; i++) begin
      step(0, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].be, vecs[i].re, vecs[i].ra);
      idle();
      if (vecs[i].re) begin
        check("vec_valid", {31'd0, rd_valid}, 32'd1);
        check("vec_data", rd_data, vecs[i].exp);
      end
      $display("vec %0d we=%0b wa=%h wd=%h be=%h re=%0b ra=%h rd_data=%h", i,
               vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].be, vecs[i].re, vecs[i].ra, rd_data);
    end

    // Write then read next cycle, back-to-back reads, and a later write not disturbing a read.
    step(0, 1, 8'h03, 32'h12345678, 4'hF, 0, 8'h00);
    step(0, 0, 8'h00, 32'h0, 4'h0, 1, 8'h03);
    step(0, 1, 8'h03, 32'h0BADF00D, 4'hF, 1, 8'h04);
    check("b2b_first", rd_data, 32'h12345678);
    idle();
    check("b2b_second", rd_data, 32'h00000000);
    check("b2b_second_valid", {31'd0, rd_valid}, 32'd1);
    idle();
    check("hold_valid_low", {31'd0, rd_valid}, 32'd0);
    check("hold_data", rd_data, 32'h00000000);

    for (int i = 0; i < 400; i++) begin
      step(0, bit'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom,
           4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), 8'($urandom_range(0, 7)));
    end
    idle(); idle();

`ifdef LOCAL_MEM_PARITY_EN
    step(0, 1, 8'h03, 32'h12345678, 4'hF, 0, 8'h00);
    u_dut.g_bank[1].r_mem[3][1] = ~u_dut.g_bank[1].r_mem[3][1];
    m_mem[3][9] = ~m_mem[3][9];
    m_bad[3] = 1;
    step(0, 0, 8'h00, 32'h0, 4'h0, 1, 8'h03);
    idle();
    check("par_flip_err", {31'd0, par_err}, 32'd1);
    check("par_flip_valid", {31'd0, rd_valid}, 32'd1);
    idle();
`endif

    // Reset mid-clear with a write attempted while clearing.
    step(1, 0, 8'h00, 32'h0, 4'h0, 0, 8'h00);
    for (int i = 0; i < 50; i++) idle();
    step(0, 1, 8'h80, 32'hDEADBEEF, 4'hF, 1, 8'h80);
    for (int i = 0; i < 49; i++) idle();
    step(1, 0, 8'h00, 32'h0, 4'h0, 0, 8'h00);
    measure_busy(blen);
    check("busy_len_restart", blen, 256);
    step(0, 0, 8'h00, 32'h0, 4'h0, 1, 8'h80);
    idle();
    check("clear_0x80", rd_data, 32'h00000000);
    check("clear_0x80_valid", {31'd0, rd_valid}, 32'd1);

    // Read issued one cycle before reset must vanish.
    step(0, 1, 8'h10, 32'hCAFEF00D, 4'hF, 0, 8'h00);
    step(0, 0, 8'h00, 32'h0, 4'h0, 1, 8'h10);
    idle();
    check("pre_rst_data_loaded", rd_data, 32'hCAFEF00D);
    step(0, 0, 8'h00, 32'h0, 4'h0, 1, 8'h10);
    step(1, 0, 8'h00, 32'h0, 4'h0, 0, 8'h00);
    check("rst_drop_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_drop_data", rd_data, 32'h00000000);
    step(0, 0, 8'h00, 32'h0, 4'h0, 0, 8'h00);
    check("rst_drop_valid_late", {31'd0, rd_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
